mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge; RST  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have processor-side inputs: iREN  in  1  instruction read request; iaddr  in  32  instruction address; dREN  in  1  data read request; dWEN  in  1  data write request; daddr  in  32  data address; dstore  in  32  write data.
REQ-003 SHALL have processor-side outputs: ihit  out  1  instruction access done; dhit  out  1  data access done; iload  out  32  fetched instruction; dload  out  32  read data; merr  out  1  sticky timeout error.
REQ-004 SHALL have RAM-side ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; ramload  in  32; ramready  in  1  RAM completes current access this cycle.
REQ-005 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of access cycles without ramready.

Function
REQ-006 SHALL implement a registered FSM with states IDLE, DACC, IACC, DHIT, IHIT.
REQ-007 IDLE: (dREN|dWEN) -> DACC; else iREN -> IACC; else stay. Data has strict priority over instruction.
REQ-008 DACC: ramaddr=daddr; ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins when both are set).
REQ-009 IACC: ramaddr=iaddr; ramREN=1; ramWEN=0; ramstore=0.
REQ-010 IDLE, DHIT, IHIT: ramREN=ramWEN=0; ramaddr=ramstore=0.
REQ-011 DACC with ramready=1 -> DHIT; on that edge dload<=ramload (read only; writes leave dload unchanged).
REQ-012 IACC with ramready=1 -> IHIT; on that edge iload<=ramload.
REQ-013 DHIT: dhit=1 for exactly one cycle, then IDLE; IHIT: ihit=1 for exactly one cycle, then IDLE.
REQ-014 ihit and dhit SHALL be decoded from state only and SHALL never be asserted together.
REQ-015 Latency: a request seen in IDLE at edge N, with ramready in cycle k of the access, gives hit in cycle N+k+1; minimum 2 cycles from request to hit.
REQ-016 iload and dload SHALL hold their value until the next completed access of the same kind.
REQ-017 Abort: in DACC with dREN=dWEN=0 and ramready=0 -> IDLE; no hit, dload unchanged. Same in IACC with iREN=0.
REQ-018 ramready has priority over abort when both occur in the same cycle.
REQ-019 SHALL keep a 4-bit wait counter: cleared on every entry to DACC/IACC; incremented each access cycle with ramready=0.
REQ-020 Counter == TIMEOUT with ramready=0 -> IDLE, merr<=1, no hit; ramready in that same cycle completes normally.
REQ-021 merr SHALL be sticky and cleared only by RST.
REQ-022 Request changes during DACC/IACC (address, data, dREN<->dWEN) SHALL pass through combinationally to the RAM side.
REQ-023 In IDLE a newly raised data request SHALL win over a simultaneously pending iREN; iREN is served on a later IDLE cycle.

Reset
REQ-024 RST=1 SHALL asynchronously force: state IDLE, counter 0, ihit=dhit=0, iload=dload=0, merr=0, all RAM outputs 0.
REQ-025 RST asserted mid-access SHALL abandon the access immediately; no hit after release.
REQ-026 After RST deasserts, the first request SHALL be accepted at the first rising CLK edge.

Verification
REQ-027 Instruction read: iREN=1, iaddr=0x40, ramready=1 in the 2nd IACC cycle with ramload=0x8C010004 -> ramREN=1 in IACC, ihit=1 one cycle later, iload=0x8C010004.
REQ-028 Contention: iREN=1 and dREN=1 (daddr=0x100) in IDLE -> DACC first, dhit, back to IDLE, then IACC, ihit; never both hits in one cycle.
REQ-029 Write with both enables: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit after ramready; dload unchanged.
REQ-030 Timeout: dREN=1 with ramready held 0 -> after 16 DACC cycles, IDLE, merr=1, dhit never asserted; merr stays 1 until RST.
REQ-031 Abort: dREN drops in DACC before ramready -> IDLE next cycle, no dhit, dload unchanged.
REQ-032 Reset mid-access: RST pulse in IACC -> all outputs 0 immediately; no ihit after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Processor-side and RAM-side signal bundle for the memory arbiter.
// master is the arbiter's view; slave is the view of the processor and RAM around it.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        merr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto a single RAM port, data first,
// with abort, a bounded wait for ramready and a sticky timeout error.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic           CLK,
  input logic           RST,
  mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {StIdle, StDacc, StIacc, StDhit, StIhit} state_e;

  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        merr_q, merr_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;

  logic        dreq;
  logic        drd;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;

  assign dreq = bus.dREN | bus.dWEN;
  // A write wins when both enables are set.
  assign drd  = bus.dREN & ~bus.dWEN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    merr_d    = merr_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    unique case (state_q)
      StIdle: begin
        if (dreq) begin
          state_d = StDacc;
          cnt_d   = '0;
        end else if (bus.iREN) begin
          state_d = StIacc;
          cnt_d   = '0;
        end
      end
      StDacc: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        ram_wen   = bus.dWEN;
        ram_ren   = drd;
        // Completion beats timeout, timeout beats abort.
        if (bus.ramready) begin
          state_d = StDhit;
          if (drd) dload_d = bus.ramload;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
          merr_d  = 1'b1;
        end else if (!dreq) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StIacc: begin
        ram_addr = bus.iaddr;
        ram_ren  = 1'b1;
        if (bus.ramready) begin
          state_d = StIhit;
          iload_d = bus.ramload;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
          merr_d  = 1'b1;
        end else if (!bus.iREN) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDhit:  state_d = StIdle;
      StIhit:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      merr_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      merr_q  <= merr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
    end
  end

  assign bus.ihit     = (state_q == StIhit);
  assign bus.dhit     = (state_q == StDhit);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.merr     = merr_q;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

endmodule
